// File: rtl/bus_word_requester.sv
// Word-to-byte bus requester: gets the bus from an arbiter, moves one word as WORD_BYTES beats and returns a pulse.
// Optional macro BUS_TIMEOUT_EN adds a grant timeout that aborts with rsp_err.
module bus_word_requester #(
  parameter int WORD_BYTES    = 4,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        grant_request,
  input  logic        grant_given,
  output logic        rw,
  output logic [8:0]  address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, RD_TAIL, DONE} state_t;

  localparam logic [1:0] LAST_IDX  = 2'(WORD_BYTES - 1);
  // Words are right-aligned: beat 0 is the most significant used byte, unused upper bytes stay 0.
  localparam logic [4:0] TOP_SHIFT = 5'(8 * (WORD_BYTES - 1));

  state_t      state_reg, state_next;
  logic        rw_reg;
  logic [8:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  idx_reg, idx_next;
  logic        pend_reg;
  logic [1:0]  pend_idx_reg;
  logic [31:0] rdata_reg;
  logic        accept;
  logic        beat;
  logic        timeout_hit;
  logic [4:0]  beat_shift;
  logic [4:0]  pend_shift;

  assign beat_shift = TOP_SHIFT - {idx_reg, 3'b000};
  assign pend_shift = TOP_SHIFT - {pend_idx_reg, 3'b000};

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    beat       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          idx_next   = 2'd0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (grant_given) state_next = XFER;
      end
      XFER: begin
        if (grant_given) begin
          beat = 1'b1;
          if (idx_reg == LAST_IDX) state_next = rw_reg ? DONE : RD_TAIL;
          else                     idx_next   = idx_reg + 2'd1;
        end
      end
      RD_TAIL: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = DONE;
  end

  assign cmd_ready     = (state_reg == IDLE);
  assign grant_request = (state_reg == REQ) || (state_reg == XFER) || (state_reg == RD_TAIL);
  assign rsp_valid     = (state_reg == DONE);
  assign rw            = beat & rw_reg;
  assign address       = beat ? (addr_reg + {7'd0, idx_reg}) : 9'd0;
  assign data_out      = beat ? wdata_reg[beat_shift +: 8] : 8'h00;
  assign rsp_rdata     = rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rw_reg       <= 1'b0;
      addr_reg     <= 9'd0;
      wdata_reg    <= 32'd0;
      idx_reg      <= 2'd0;
      pend_reg     <= 1'b0;
      pend_idx_reg <= 2'd0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      // A read byte arrives one cycle after its address, whatever grant does meanwhile.
      pend_reg     <= beat & ~rw_reg;
      pend_idx_reg <= idx_reg;
      if (accept) begin
        rw_reg    <= cmd_rw;
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
        rdata_reg <= 32'd0;
      end else if (timeout_hit) begin
        rdata_reg <= 32'd0;
      end else if (pend_reg) begin
        rdata_reg[pend_shift +: 8] <= data_in;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(GRANT_TIMEOUT - 1);

  logic [TW-1:0] to_cnt_reg;
  logic          waiting;
  logic          err_reg;

  assign waiting     = ((state_reg == REQ) || (state_reg == XFER)) && !grant_given;
  assign timeout_hit = waiting && (to_cnt_reg == TO_LAST);
  assign rsp_err     = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (waiting && !timeout_hit) to_cnt_reg <= to_cnt_reg + 1'b1;
      else                         to_cnt_reg <= '0;
      if (accept)           err_reg <= 1'b0;
      else if (timeout_hit) err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // No abort path in this build; GRANT_TIMEOUT is always positive, so this is 0.
  assign rsp_err     = (GRANT_TIMEOUT < 0);
`endif

endmodule
